// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit Harvard datapath: widths, FSM state
// encoding and the memory-latency counter width.
package proc_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 5;
  localparam int MEM_ADDR_W = 16;
  localparam int LAT_CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REG_RD    = 3'd1,
    MEM_ISSUE = 3'd2,
    MEM_WAIT  = 3'd3,
    RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/rd_lat_counter.sv
// Loadable up-counter that flags when the data-memory read latency has elapsed.
module rd_lat_counter
  import proc_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic inc,
  output logic done
);

  localparam logic [LAT_CNT_W-1:0] TERMINAL = LAT_CNT_W'(MEM_LAT);

  logic [LAT_CNT_W-1:0] lat_cnt;

  // Loads to 1 on the strobe cycle so the count equals cycles since the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (load) begin
      lat_cnt <= LAT_CNT_W'(1);
    end else if (inc) begin
      lat_cnt <= lat_cnt + 1'b1;
    end
  end

  assign done = (lat_cnt == TERMINAL);

endmodule

// File: rtl/operand_read_unit.sv
// Operand read unit: register-pair reads and data-memory loads over valid/ready.
// Optional same-cycle write-back forwarding is enabled by OPERAND_READ_BYPASS_EN.
module operand_read_unit
  import proc_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_mem,
  input  logic [REG_ADDR_W-1:0] req_reg_a,
  input  logic [REG_ADDR_W-1:0] req_reg_b,
  input  logic [MEM_ADDR_W-1:0] req_mem_addr,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_a,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_b,
  input  logic [DATA_W-1:0]     rf_rd_data_a,
  input  logic [DATA_W-1:0]     rf_rd_data_b,
`ifdef OPERAND_READ_BYPASS_EN
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_dest,
  input  logic [DATA_W-1:0]     wb_write_data,
`endif
  output logic                  dm_rd_en,
  output logic [MEM_ADDR_W-1:0] dm_rd_addr,
  input  logic [DATA_W-1:0]     dm_rd_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_data_a,
  output logic [DATA_W-1:0]     resp_data_b,
  output logic                  resp_is_mem
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("operand_read_unit: MEM_LAT must be in 1..15");
  end

  state_t state, state_nxt;

  logic [REG_ADDR_W-1:0] reg_a_p0, reg_b_p0;
  logic [MEM_ADDR_W-1:0] addr_p0;
  logic                  is_mem_p0;
  logic [DATA_W-1:0]     data_a_p1, data_b_p1;
  logic [DATA_W-1:0]     opnd_a, opnd_b;
  logic                  accept;
  logic                  cnt_load, cnt_inc, lat_done;

  rd_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .done  (lat_done)
  );

`ifdef OPERAND_READ_BYPASS_EN
  function automatic logic [DATA_W-1:0] pick_operand(
    input logic [DATA_W-1:0]     rf_data,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  we,
    input logic [REG_ADDR_W-1:0] dest,
    input logic [DATA_W-1:0]     wdata
  );
    return (we && (dest == src)) ? wdata : rf_data;
  endfunction

  assign opnd_a = pick_operand(rf_rd_data_a, reg_a_p0, wb_reg_write, wb_write_dest, wb_write_data);
  assign opnd_b = pick_operand(rf_rd_data_b, reg_b_p0, wb_reg_write, wb_write_dest, wb_write_data);
`else
  assign opnd_a = rf_rd_data_a;
  assign opnd_b = rf_rd_data_b;
`endif

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) state_nxt = req_is_mem ? MEM_ISSUE : REG_RD;
      end
      REG_RD: state_nxt = RESP;
      MEM_ISSUE: begin
        cnt_load  = 1'b1;
        state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (lat_done) state_nxt = RESP;
        else          cnt_inc   = 1'b1;
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: request fields latched on accept; they drive the read ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      reg_a_p0  <= '0;
      reg_b_p0  <= '0;
      addr_p0   <= '0;
      is_mem_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        reg_a_p0  <= req_reg_a;
        reg_b_p0  <= req_reg_b;
        addr_p0   <= req_mem_addr;
        is_mem_p0 <= req_is_mem;
      end
    end
  end

  // Stage p1: response data captured from the register file or the memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_a_p1 <= '0;
      data_b_p1 <= '0;
    end else if (state == REG_RD) begin
      data_a_p1 <= opnd_a;
      data_b_p1 <= opnd_b;
    end else if (state == MEM_WAIT && lat_done) begin
      data_a_p1 <= dm_rd_data;
      data_b_p1 <= '0;
    end
  end

  assign rf_rd_addr_a = reg_a_p0;
  assign rf_rd_addr_b = reg_b_p0;
  assign dm_rd_addr   = addr_p0;
  assign dm_rd_en     = (state == MEM_ISSUE);
  assign resp_valid   = (state == RESP);
  assign resp_data_a  = data_a_p1;
  assign resp_data_b  = data_b_p1;
  assign resp_is_mem  = is_mem_p0;

endmodule

// File: tb/tb_operand_read_unit.sv
// Directed table-driven bench for operand_read_unit (MEM_LAT=3), with
// hand-written backpressure and mid-load reset sequences.
module tb_operand_read_unit;

  localparam int MEM_LAT = 3;

`ifdef OPERAND_READ_BYPASS_EN
  localparam logic [15:0] FWD5 = 16'h0099;
`else
  localparam logic [15:0] FWD5 = 16'h0001;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_mem;
  logic [4:0]  req_reg_a, req_reg_b;
  logic [15:0] req_mem_addr;
  logic [4:0]  rf_rd_addr_a, rf_rd_addr_b;
  logic [15:0] rf_rd_data_a, rf_rd_data_b;
  logic        wb_reg_write;
  logic [4:0]  wb_write_dest;
  logic [15:0] wb_write_data;
  logic        dm_rd_en;
  logic [15:0] dm_rd_addr, dm_rd_data;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_data_a, resp_data_b;
  logic        resp_is_mem;

  logic [15:0] rf [32];
  logic [15:0] mem_value;
  logic [15:0] en_pipe = '0;

  int n_applied = 0;
  int n_miscompare = 0;

  always #5 clk = ~clk;

  operand_read_unit #(.MEM_LAT(MEM_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_mem   (req_is_mem),
    .req_reg_a    (req_reg_a),
    .req_reg_b    (req_reg_b),
    .req_mem_addr (req_mem_addr),
    .rf_rd_addr_a (rf_rd_addr_a),
    .rf_rd_addr_b (rf_rd_addr_b),
    .rf_rd_data_a (rf_rd_data_a),
    .rf_rd_data_b (rf_rd_data_b),
`ifdef OPERAND_READ_BYPASS_EN
    .wb_reg_write (wb_reg_write),
    .wb_write_dest(wb_write_dest),
    .wb_write_data(wb_write_data),
`endif
    .dm_rd_en     (dm_rd_en),
    .dm_rd_addr   (dm_rd_addr),
    .dm_rd_data   (dm_rd_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data_a  (resp_data_a),
    .resp_data_b  (resp_data_b),
    .resp_is_mem  (resp_is_mem)
  );

  // Register file is combinational; memory returns data MEM_LAT cycles after the strobe cycle.
  assign rf_rd_data_a = rf[rf_rd_addr_a];
  assign rf_rd_data_b = rf[rf_rd_addr_b];
  always @(posedge clk) en_pipe <= {en_pipe[14:0], dm_rd_en};
  assign dm_rd_data = en_pipe[MEM_LAT-1] ? mem_value : 16'hDEAD;

  typedef struct {
    logic        is_mem;
    logic [4:0]  ra, rb;
    logic [15:0] addr, mem_val;
    logic        wb_we;
    logic [4:0]  wb_dest;
    logic [15:0] wb_data;
    logic [15:0] exp_a, exp_b;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int en_cnt;
    @(negedge clk);
    check($sformatf("v%0d_req_ready_idle", idx), 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_is_mem   = v.is_mem;
    req_reg_a    = v.ra;
    req_reg_b    = v.rb;
    req_mem_addr = v.addr;
    mem_value    = v.mem_val;
    @(posedge clk); #1;
    req_valid     = 1'b0;
    wb_reg_write  = v.wb_we;
    wb_write_dest = v.wb_dest;
    wb_write_data = v.wb_data;
    cyc = 1;
    en_cnt = 0;
    while (!resp_valid && cyc < 40) begin
      if (dm_rd_en) begin
        en_cnt++;
        check($sformatf("v%0d_dm_rd_addr", idx), 32'(dm_rd_addr), 32'(v.addr));
      end
      @(posedge clk); #1;
      wb_reg_write = 1'b0;
      cyc++;
    end
    check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.exp_lat));
    check($sformatf("v%0d_dm_rd_en_pulses", idx), 32'(en_cnt), v.is_mem ? 32'd1 : 32'd0);
    check($sformatf("v%0d_data_a", idx), 32'(resp_data_a), 32'(v.exp_a));
    check($sformatf("v%0d_data_b", idx), 32'(resp_data_b), 32'(v.exp_b));
    check($sformatf("v%0d_is_mem", idx), 32'(resp_is_mem), 32'(v.is_mem));
    @(posedge clk); #1;
    check($sformatf("v%0d_resp_valid_drop", idx), 32'(resp_valid), 32'd0);
    check($sformatf("v%0d_req_ready_back", idx), 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 32; i++) rf[i] = 16'h1000 + 16'(i);
    rf[0] = 16'h7777; rf[3] = 16'h1234; rf[5] = 16'h0001;
    rf[7] = 16'hBEEF; rf[31] = 16'h8001;

    vecs[0] = '{1'b0, 5'd3, 5'd7,  16'h0000, 16'h0000, 1'b0, 5'd0, 16'h0000, 16'h1234, 16'hBEEF, 2};
    vecs[1] = '{1'b1, 5'd0, 5'd0,  16'h0040, 16'hA5A5, 1'b0, 5'd0, 16'h0000, 16'hA5A5, 16'h0000, 5};
    vecs[2] = '{1'b0, 5'd0, 5'd31, 16'h0000, 16'h0000, 1'b0, 5'd0, 16'h0000, 16'h7777, 16'h8001, 2};
    vecs[3] = '{1'b1, 5'd4, 5'd9,  16'hFFFF, 16'h0F0F, 1'b0, 5'd0, 16'h0000, 16'h0F0F, 16'h0000, 5};
    vecs[4] = '{1'b0, 5'd5, 5'd7,  16'h0000, 16'h0000, 1'b1, 5'd5, 16'h0099, FWD5,     16'hBEEF, 2};
    vecs[5] = '{1'b0, 5'd5, 5'd5,  16'h0000, 16'h0000, 1'b1, 5'd5, 16'h0099, FWD5,     FWD5,     2};
    vecs[6] = '{1'b0, 5'd5, 5'd7,  16'h0000, 16'h0000, 1'b1, 5'd9, 16'h0099, 16'h0001, 16'hBEEF, 2};
    vecs[7] = '{1'b0, 5'd7, 5'd3,  16'h0000, 16'h0000, 1'b0, 5'd7, 16'h0099, 16'hBEEF, 16'h1234, 2};

    reset = 1'b1; req_valid = 1'b0; req_is_mem = 1'b0; req_reg_a = '0; req_reg_b = '0;
    req_mem_addr = '0; wb_reg_write = 1'b0; wb_write_dest = '0; wb_write_data = '0;
    resp_ready = 1'b1; mem_value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_dm_rd_en", 32'(dm_rd_en), 32'd0);
    check("rst_dm_rd_addr", 32'(dm_rd_addr), 32'd0);
    check("rst_rf_addr_a", 32'(rf_rd_addr_a), 32'd0);
    check("rst_data_a", 32'(resp_data_a), 32'd0);
    check("rst_data_b", 32'(resp_data_b), 32'd0);
    check("rst_is_mem", 32'(resp_is_mem), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure: response held 10 cycles while a second request waits.
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_is_mem = 1'b0; req_reg_a = 5'd3; req_reg_b = 5'd7;
    @(posedge clk); #1;
    req_reg_a = 5'd7; req_reg_b = 5'd3;
    cyc = 0;
    while (!resp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("bp_resp_seen", 32'(resp_valid), 32'd1);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp%0d_resp_valid", k), 32'(resp_valid), 32'd1);
      check($sformatf("bp%0d_data_a", k), 32'(resp_data_a), 32'h1234);
      check($sformatf("bp%0d_data_b", k), 32'(resp_data_b), 32'hBEEF);
      check($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_hs_resp_valid", 32'(resp_valid), 32'd0);
    check("bp_after_hs_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_second_accepted", 32'(req_ready), 32'd0);
    cyc = 1;
    while (!resp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check("bp_second_latency", 32'(cyc), 32'd2);
    check("bp_second_data_a", 32'(resp_data_a), 32'hBEEF);
    check("bp_second_data_b", 32'(resp_data_b), 32'h1234);
    @(posedge clk); #1;

    // Reset during MEM_WAIT; the late memory data must be ignored.
    @(negedge clk);
    mem_value = 16'hFFFF;
    req_valid = 1'b1; req_is_mem = 1'b1; req_mem_addr = 16'h0080;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mr_req_ready", 32'(req_ready), 32'd1);
    check("mr_dm_rd_en", 32'(dm_rd_en), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mr%0d_resp_valid", k), 32'(resp_valid), 32'd0);
      check($sformatf("mr%0d_data_a", k), 32'(resp_data_a), 32'd0);
      @(posedge clk); #1;
    end
    run_vec(vecs[0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
    $finish;
  end

endmodule
